// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: access-size encodings seen by DataMemory,
// the store buffer's FSM states and its entry record.
package mem_pkg;

  typedef enum logic [1:0] {
    MT_BYTE     = 2'b00,
    MT_HALF     = 2'b01,
    MT_WORD_ALT = 2'b10,  // DataMemory treats this as a word access
    MT_WORD     = 2'b11
  } mem_type_e;

  typedef enum logic {
    SB_RUN    = 1'b0,
    SB_HAZARD = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mtype;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of pending stores with head/tail pointers and an occupancy count;
// every entry's address and validity are exposed for the load hazard compare.
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   i_push,
  input  logic [31:0]            i_push_addr,
  input  logic [31:0]            i_push_data,
  input  logic [1:0]             i_push_type,
  input  logic                   i_pop,
  output logic [31:0]            o_head_addr,
  output logic [31:0]            o_head_data,
  output logic [1:0]             o_head_type,
  output logic [DEPTH-1:0]       o_head_onehot,
  output logic [DEPTH-1:0][31:0] o_entry_addr,
  output logic [DEPTH-1:0]       o_valid,
  output logic [PTR_W:0]         o_count
);

  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_offset;

  // NOTE: entry storage is deliberately not reset; an entry is only ever read
  // while head/count mark it valid, so stale contents are never observed.
  always_ff @(posedge Clk) begin
    if (i_push) begin
      r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data, mtype: i_push_type};
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_offset     = '0;
    o_valid      = '0;
    o_entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from head, modulo DEPTH, decides whether slot i is occupied.
      w_offset        = PTR_W'(i) - r_head;
      o_valid[i]      = ({1'b0, w_offset} < r_count);
      o_entry_addr[i] = r_mem[i].addr;
    end
  end

  assign o_head_addr   = r_mem[r_head].addr;
  assign o_head_data   = r_mem[r_head].data;
  assign o_head_type   = r_mem[r_head].mtype;
  assign o_head_onehot = DEPTH'(1) << r_head;
  assign o_count       = r_count;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and DataMemory: posts stores into a FIFO,
// lets non-conflicting loads bypass it, and stalls loads that hit a buffered word.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] CpuAddress,
  input  logic [31:0] CpuWriteData,
  input  logic        CpuMemWrite,
  input  logic        CpuMemRead,
  input  logic [1:0]  CpuMemType,
  output logic [31:0] CpuReadData,
  output logic        Stall,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [1:0]  MemType,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  sb_state_e               r_state;
  sb_state_e               w_state_next;
  logic                    w_load_req;
  logic                    w_claim;
  logic                    w_hold;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_hazard;
  logic [DEPTH-1:0]        w_match;
  logic [DEPTH-1:0]        w_match_after;
  logic [DEPTH-1:0]        w_valid;
  logic [DEPTH-1:0]        w_head_onehot;
  logic [DEPTH-1:0][31:0]  w_entry_addr;
  logic [31:0]             w_head_addr;
  logic [31:0]             w_head_data;
  logic [1:0]              w_head_type;
  logic [PTR_W:0]          w_count;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_push       (w_push),
    .i_push_addr  (CpuAddress),
    .i_push_data  (CpuWriteData),
    .i_push_type  (CpuMemType),
    .i_pop        (w_pop),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_head_type  (w_head_type),
    .o_head_onehot(w_head_onehot),
    .o_entry_addr (w_entry_addr),
    .o_valid      (w_valid),
    .o_count      (w_count)
  );

  // A request with both strobes set is a store; only a pure read is a load.
  assign w_load_req = CpuMemRead & ~CpuMemWrite;
  assign w_full     = (w_count == (PTR_W+1)'(DEPTH));

  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = w_valid[i] && (w_entry_addr[i][31:2] == CpuAddress[31:2]);
    end
  end

  assign w_hazard      = |w_match;
  assign w_claim       = (r_state == SB_RUN) && w_load_req && !w_hazard && !Reset;
  assign w_pop         = (w_count != '0) && !w_claim;
  // Matches that will still be buffered after this cycle's drain.
  assign w_match_after = w_match & ~(w_pop ? w_head_onehot : '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= SB_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b0;
    unique case (r_state)
      SB_RUN: begin
        if (w_load_req && w_hazard) begin
          w_hold       = 1'b1;
          w_state_next = SB_HAZARD;
        end
      end
      SB_HAZARD: begin
        w_hold = 1'b1;
        if (!(|w_match_after)) w_state_next = SB_RUN;
      end
      default: w_state_next = SB_RUN;
    endcase
  end

  assign Stall  = w_hold || (CpuMemWrite && w_full);
  assign w_push = CpuMemWrite && !Stall;

  always_comb begin
    MemAddress   = '0;
    MemWriteData = '0;
    MemType      = '0;
    if (w_claim) begin
      MemAddress = CpuAddress;
      MemType    = CpuMemType;
    end else if (w_pop) begin
      MemAddress   = w_head_addr;
      MemWriteData = w_head_data;
      MemType      = w_head_type;
    end
  end

  assign MemRead     = w_claim;
  assign MemWrite    = w_pop;
  assign CpuReadData = w_claim ? MemReadData : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then randomized
// traffic, checked against an architectural memory and a queue of pending stores.
module tb_store_buffer;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic [31:0] CpuAddress;
  logic [31:0] CpuWriteData;
  logic        CpuMemWrite;
  logic        CpuMemRead;
  logic [1:0]  CpuMemType;
  logic [31:0] CpuReadData;
  logic        Stall;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [1:0]  MemType;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .CpuAddress  (CpuAddress),
    .CpuWriteData(CpuWriteData),
    .CpuMemWrite (CpuMemWrite),
    .CpuMemRead  (CpuMemRead),
    .CpuMemType  (CpuMemType),
    .CpuReadData (CpuReadData),
    .Stall       (Stall),
    .MemAddress  (MemAddress),
    .MemWriteData(MemWriteData),
    .MemType     (MemType),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemReadData (MemReadData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] dmem [256];   // DataMemory as seen by the DUT
  logic [31:0] amem [256];   // architectural memory: every accepted store in order
  sb_entry_t   sq [$];       // stores accepted but not yet written to DataMemory
  logic        waiting = 1'b0;
  logic        s_stall, s_mem_write, s_mem_read;
  logic [31:0] s_rdata, s_maddr, s_wdata;
  logic [1:0]  s_mtype;

  function automatic logic [31:0] init_val(input int i);
    return 32'h9E3779B9 * i;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] t);
    logic [31:0] w;
    w = old;
    if (t == 2'b00)      w[8*a[1:0] +: 8]  = d[7:0];
    else if (t == 2'b01) w[16*a[1]  +: 16] = d[15:0];
    else                 w = d;
    return w;
  endfunction

  assign MemReadData = dmem[MemAddress[9:2]];

  always @(posedge Clk) begin
    if (MemWrite) dmem[MemAddress[9:2]] <= merge(dmem[MemAddress[9:2]], MemAddress, MemWriteData, MemType);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MEM-stage cycle: apply a request, check every output against the model,
  // cross the clock edge and retire what the model says happened.
  task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] t, output logic stalled);
    logic      load, match, e_claim, e_stall, e_drain, remain;
    sb_entry_t e;
    CpuMemWrite = w; CpuMemRead = r; CpuAddress = a; CpuWriteData = d; CpuMemType = t;
    #1;
    load  = r && !w;
    match = 1'b0;
    foreach (sq[k]) if (sq[k].addr[31:2] == a[31:2]) match = 1'b1;
    e_claim = load && !waiting && !match;
    e_stall = (w && sq.size() == DEPTH) || waiting || (load && match);
    e_drain = (sq.size() != 0) && !e_claim;
    s_stall = Stall; s_mem_write = MemWrite; s_mem_read = MemRead;
    s_rdata = CpuReadData; s_maddr = MemAddress; s_wdata = MemWriteData; s_mtype = MemType;
    check("stall", 32'(Stall), 32'(e_stall));
    check("mem_read", 32'(MemRead), 32'(e_claim));
    check("mem_write", 32'(MemWrite), 32'(e_drain));
    if (e_drain) begin
      check("drain_addr", MemAddress, sq[0].addr);
      check("drain_data", MemWriteData, sq[0].data);
      check("drain_type", 32'(MemType), 32'(sq[0].mtype));
    end
    if (e_claim) begin
      check("load_addr", MemAddress, a);
      check("load_type", 32'(MemType), 32'(t));
      check("load_data", CpuReadData, amem[a[9:2]]);
    end else begin
      check("idle_rdata", CpuReadData, 32'h0);
    end
    stalled = e_stall;
    @(posedge Clk);
    #1;
    if (e_drain) void'(sq.pop_front());
    if (w && !e_stall) begin
      e.addr = a; e.data = d; e.mtype = t;
      sq.push_back(e);
      amem[a[9:2]] = merge(amem[a[9:2]], a, d, t);
    end
    if (waiting) begin
      remain = 1'b0;
      foreach (sq[k]) if (sq[k].addr[31:2] == a[31:2]) remain = 1'b1;
      if (!remain) waiting = 1'b0;
    end else if (load && match) begin
      waiting = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, st);
  endtask

  initial begin
    logic        st, hold, w, r;
    logic [31:0] a, d;
    logic [1:0]  t;
    logic [31:0] v;
    int          held, roll;

    for (int i = 0; i < 256; i++) begin
      dmem[i] = init_val(i);
      amem[i] = init_val(i);
    end
    Reset = 1'b1; CpuMemWrite = 1'b0; CpuMemRead = 1'b1; CpuAddress = 32'h200;
    CpuWriteData = '0; CpuMemType = 2'b11;
    #12;
    check("rst_stall", 32'(Stall), 32'h0);
    check("rst_mem_write", 32'(MemWrite), 32'h0);
    check("rst_mem_read", 32'(MemRead), 32'h0);
    check("rst_rdata", CpuReadData, 32'h0);
    Reset = 1'b0;

    // Posted word store drains the following cycle, then the buffer is empty.
    cycle(1'b1, 1'b0, 32'h1C5D0F08, 32'hAA6332A4, 2'b11, st);
    check("s1_accept", 32'(s_stall), 32'h0);
    idle(1);
    check("s1_we", 32'(s_mem_write), 32'h1);
    check("s1_addr", s_maddr, 32'h1C5D0F08);
    check("s1_data", s_wdata, 32'hAA6332A4);
    check("s1_type", 32'(s_mtype), 32'(MT_WORD));
    idle(1);
    check("s1_empty", 32'(s_mem_write), 32'h0);

    // Load to a different word bypasses the buffered store; drain waits a cycle.
    cycle(1'b1, 1'b0, 32'h100, 32'h0000005A, 2'b00, st);
    cycle(1'b0, 1'b1, 32'h200, 32'h0, 2'b11, st);
    check("byp_stall", 32'(s_stall), 32'h0);
    check("byp_read", 32'(s_mem_read), 32'h1);
    check("byp_we", 32'(s_mem_write), 32'h0);
    check("byp_data", s_rdata, init_val(32'h80));
    idle(1);
    check("byp_late_we", 32'(s_mem_write), 32'h1);
    check("byp_late_addr", s_maddr, 32'h100);

    // Load hitting a buffered byte stalls until the entry drains, then sees the merge.
    cycle(1'b1, 1'b0, 32'h100, 32'h000000A5, 2'b00, st);
    cycle(1'b0, 1'b1, 32'h100, 32'h0, 2'b11, st);
    check("haz_stall0", 32'(s_stall), 32'h1);
    check("haz_read0", 32'(s_mem_read), 32'h0);
    cycle(1'b0, 1'b1, 32'h100, 32'h0, 2'b11, st);
    check("haz_stall1", 32'(s_stall), 32'h1);
    cycle(1'b0, 1'b1, 32'h100, 32'h0, 2'b11, st);
    v = init_val(32'h40);
    check("haz_stall2", 32'(s_stall), 32'h0);
    check("haz_merged", s_rdata, {v[31:8], 8'hA5});

    // Stores interleaved with non-hazard loads, and a store+load request.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 2'b11, st);
      cycle(1'b0, 1'b1, 32'h380, 32'h0, 2'b11, st);
    end
    cycle(1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 2'b11, st);
    check("both_is_store", 32'(s_mem_read), 32'h0);
    idle(3);

    // Reset with a store pending: it must never reach DataMemory.
    cycle(1'b1, 1'b0, 32'h140, 32'hDEADBEEF, 2'b11, st);
    CpuMemWrite = 1'b0; CpuMemRead = 1'b0;
    Reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(Stall), 32'h0);
    check("mid_rst_we", 32'(MemWrite), 32'h0);
    check("mid_rst_count", 32'(dut.u_fifo.r_count), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sq.delete();
    waiting = 1'b0;
    for (int i = 0; i < 256; i++) amem[i] = dmem[i];
    idle(4);
    check("rst_discard", dmem[32'h50], init_val(32'h50));

    // Randomized MEM-stage traffic over a few words so hazards are frequent.
    hold = 1'b0; held = 0;
    w = 1'b0; r = 1'b0; a = '0; d = '0; t = '0;
    for (int n = 0; n < 800; n++) begin
      if (!hold) begin
        roll = $urandom_range(0, 99);
        w = (roll < 40) || (roll >= 80 && roll < 85);
        r = (roll >= 40 && roll < 85);
        t = 2'($urandom_range(0, 3));
        a = 32'h100 + 32'($urandom_range(0, 7) * 4);
        if (t == 2'b00)      a = a + 32'($urandom_range(0, 3));
        else if (t == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
        d = $urandom;
      end
      cycle(w, r, a, d, t, st);
      hold = st;
      held = st ? held + 1 : 0;
      if (held > 32) begin
        check("hold_bound", 32'(held), 32'h0);
        hold = 1'b0;
        held = 0;
      end
    end

    for (int i = 0; i < 16 && sq.size() != 0; i++) idle(1);
    idle(1);
    check("final_empty", 32'(sq.size()), 32'h0);
    for (int i = 0; i < 256; i++) check("final_mem", dmem[i], amem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
